// File: rtl/tracking_pkg.sv
// Shared constants for the colour tracker and its pan/tilt mapper: video window,
// home position, Q0.10 gains and controller state encodings.
package tracking_pkg;

    localparam int X_MIN      = 34;
    localparam int X_MAX      = 754;
    localparam int Y_MIN      = 71;
    localparam int Y_MAX      = 767;
    localparam int X_W        = 11;
    localparam int Y_W        = 10;

    // floor(255*1024/window_width), so the far window edge lands just under 255
    localparam int PAN_SCALE  = 362;
    localparam int TILT_SCALE = 375;

    localparam int MAX_STEP   = 8;
    localparam int HOME_PAN   = 128;
    localparam int HOME_TILT  = 128;

    localparam int unsigned LOST_CYCLES_DEF = 4_000_000;
    localparam int          LOST_CNT_W      = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCALE   = 2'd1,
        ST_SLEW    = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    function automatic int prod_width(input int cw, input int scale);
        return cw + $clog2(scale + 1);
    endfunction

endpackage

// File: rtl/axis_mapper.sv
// One axis of the pan/tilt mapping: clamp to the video window, Q0.10 scale to
// 0..255, then slew-limit the presented position toward that target.
module axis_mapper
    import tracking_pkg::*;
#(
    parameter int CW       = 11,
    parameter int MIN      = 34,
    parameter int MAX      = 754,
    parameter int SCALE    = 362,
    parameter int STEP     = 8,
    parameter int HOME     = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] coord_i,
    input  logic          scale_en_i,
    input  logic          home_en_i,
    input  logic          slew_en_i,
    output logic [7:0]    pos_o,
    output logic          at_target_o
);

    localparam int PW = prod_width(CW, SCALE);
    localparam logic [CW-1:0]     MIN_C  = CW'(MIN);
    localparam logic [CW-1:0]     MAX_C  = CW'(MAX);
    localparam logic signed [8:0] STEP_S = 9'(STEP);

    logic [CW-1:0]     clamped;
    logic [CW-1:0]     offset;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     shifted;
    logic [7:0]        tgt_d, tgt_q;
    logic [7:0]        cur_d, cur_q;
    logic signed [8:0] diff;

    always_comb begin
        clamped = coord_i;
        if (coord_i < MIN_C)
            clamped = MIN_C;
        else if (coord_i > MAX_C)
            clamped = MAX_C;
        offset  = clamped - MIN_C;
        prod    = PW'(offset) * PW'(SCALE);
        shifted = prod >> 10;
        tgt_d   = (shifted > PW'(255)) ? 8'hFF : shifted[7:0];
    end

    // 9-bit signed difference keeps the step direction exact across the full 0..255 range
    always_comb begin
        diff  = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
        cur_d = tgt_q;
        if (diff > STEP_S)
            cur_d = cur_q + 8'(STEP);
        else if (diff < -STEP_S)
            cur_d = cur_q - 8'(STEP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_q <= 8'(HOME);
            cur_q <= 8'(HOME);
        end else begin
            if (home_en_i)
                tgt_q <= 8'(HOME);
            else if (scale_en_i)
                tgt_q <= tgt_d;
            if (slew_en_i)
                cur_q <= cur_d;
        end
    end

    assign pos_o       = cur_q;
    assign at_target_o = (cur_q == tgt_q);

endmodule

// File: rtl/com_to_pan_tilt.sv
// Tracker centre-of-mass to DMX pan/tilt converter: capture/pending slot, lost-target
// timer, sequencing FSM and valid/ack handoff to the DMX buffer.
module com_to_pan_tilt
    import tracking_pkg::*;
#(
    parameter int unsigned LOST_CYCLES = LOST_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x_com,
    input  logic [9:0]  y_com,
    input  logic        data_ready,
    output logic [7:0]  pan,
    output logic [7:0]  tilt,
    output logic        update_valid,
    input  logic        update_ack,
    output logic        tracking
);

    localparam logic [LOST_CNT_W-1:0] LOST_LAST = LOST_CNT_W'(LOST_CYCLES - 1);

    state_e                state_q;
    logic [X_W-1:0]        cap_x_q, work_x_q;
    logic [Y_W-1:0]        cap_y_q, work_y_q;
    logic                  pend_q;
    logic [LOST_CNT_W-1:0] cnt_q;
    logic                  valid_q;
    logic                  trk_q;

    logic handshake;
    logic lost_evt;
    logic consume;
    logic pan_at, tilt_at;

    // A strobe in the same cycle as a would-be lost event keeps tracking alive
    always_comb begin
        handshake = (state_q == ST_PRESENT) && valid_q && update_ack;
        lost_evt  = (state_q == ST_IDLE) && !pend_q && trk_q && !data_ready &&
                    (cnt_q == LOST_LAST);
        consume   = pend_q && ((state_q == ST_IDLE) || handshake);
    end

    // Every strobe lands in the pending slot first; IDLE and PRESENT drain it from there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cap_x_q  <= '0;
            cap_y_q  <= '0;
            work_x_q <= '0;
            work_y_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            trk_q    <= 1'b0;
        end else begin
            if (data_ready) begin
                cap_x_q <= x_com;
                cap_y_q <= y_com;
                pend_q  <= 1'b1;
                cnt_q   <= '0;
                trk_q   <= 1'b1;
            end else begin
                if (consume)
                    pend_q <= 1'b0;
                if (cnt_q != LOST_LAST)
                    cnt_q <= cnt_q + LOST_CNT_W'(1);
                if (lost_evt)
                    trk_q <= 1'b0;
            end

            if (consume) begin
                work_x_q <= cap_x_q;
                work_y_q <= cap_y_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (consume)
                        state_q <= ST_SCALE;
                    else if (lost_evt)
                        state_q <= ST_SLEW;
                end
                ST_SCALE: state_q <= ST_SLEW;
                ST_SLEW: begin
                    state_q <= ST_PRESENT;
                    valid_q <= 1'b1;
                end
                ST_PRESENT: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (consume)
                            state_q <= ST_SCALE;
                        else if (!pan_at || !tilt_at)
                            state_q <= ST_SLEW;
                        else
                            state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    axis_mapper #(
        .CW    (X_W),
        .MIN   (X_MIN),
        .MAX   (X_MAX),
        .SCALE (PAN_SCALE),
        .STEP  (MAX_STEP),
        .HOME  (HOME_PAN)
    ) u_pan (
        .clk         (clk),
        .reset       (reset),
        .coord_i     (work_x_q),
        .scale_en_i  (state_q == ST_SCALE),
        .home_en_i   (lost_evt),
        .slew_en_i   (state_q == ST_SLEW),
        .pos_o       (pan),
        .at_target_o (pan_at)
    );

    axis_mapper #(
        .CW    (Y_W),
        .MIN   (Y_MIN),
        .MAX   (Y_MAX),
        .SCALE (TILT_SCALE),
        .STEP  (MAX_STEP),
        .HOME  (HOME_TILT)
    ) u_tilt (
        .clk         (clk),
        .reset       (reset),
        .coord_i     (work_y_q),
        .scale_en_i  (state_q == ST_SCALE),
        .home_en_i   (lost_evt),
        .slew_en_i   (state_q == ST_SLEW),
        .pos_o       (tilt),
        .at_target_o (tilt_at)
    );

    assign update_valid = valid_q;
    assign tracking     = trk_q;

endmodule

// File: tb/tb_com_to_pan_tilt.sv
// Self-checking bench for com_to_pan_tilt: random coordinates against a per-update
// reference model of window mapping and slew limiting.
module tb_com_to_pan_tilt;

    localparam int LOST = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_com;
    logic [9:0]  y_com;
    logic        data_ready;
    logic [7:0]  pan;
    logic [7:0]  tilt;
    logic        update_valid;
    logic        update_ack;
    logic        tracking;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_pan, m_tilt, t_pan, t_tilt;

    com_to_pan_tilt #(.LOST_CYCLES(LOST)) dut (
        .clk          (clk),
        .reset        (reset),
        .x_com        (x_com),
        .y_com        (y_com),
        .data_ready   (data_ready),
        .pan          (pan),
        .tilt         (tilt),
        .update_valid (update_valid),
        .update_ack   (update_ack),
        .tracking     (tracking)
    );

    always #5 clk = ~clk;

    function automatic int map_axis(input int c, input int mn, input int mx, input int sc);
        int cl;
        int v;
        cl = (c < mn) ? mn : ((c > mx) ? mx : c);
        v  = ((cl - mn) * sc) / 1024;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int step(input int cur, input int tgt);
        if (tgt - cur > 8) return cur + 8;
        if (cur - tgt > 8) return cur - 8;
        return tgt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_target(input int x, input int y);
        t_pan  = map_axis(x, 34, 754, 362);
        t_tilt = map_axis(y, 71, 767, 375);
    endtask

    task automatic strobe(input int x, input int y);
        x_com      = 11'(x);
        y_com      = 10'(y);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        m_pan = 128; m_tilt = 128; t_pan = 128; t_tilt = 128;
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (update_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_valid: update_valid not seen within %0d cycles", budget);
        end
    endtask

    task automatic drain(input int budget);
        int idle = 0;
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (update_valid === 1'b1 && update_ack === 1'b1) begin
                checks++;
                if (m_pan == t_pan && m_tilt == t_tilt) begin
                    errors++;
                    $display("FAIL extra_update: pan=%0d tilt=%0d offered after target %0d/%0d reached",
                             pan, tilt, t_pan, t_tilt);
                end
                m_pan  = step(m_pan, t_pan);
                m_tilt = step(m_tilt, t_tilt);
                checks++;
                if (pan !== 8'(m_pan) || tilt !== 8'(m_tilt)) begin
                    errors++;
                    $display("FAIL drain_update: got pan=%0d tilt=%0d expected pan=%0d tilt=%0d",
                             pan, tilt, m_pan, m_tilt);
                end
                idle = 0;
            end else begin
                idle++;
                if (idle >= 6 && m_pan == t_pan && m_tilt == t_tilt) done = 1'b1;
            end
            if (!done) tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: model at %0d/%0d target %0d/%0d dut at %0d/%0d",
                     m_pan, m_tilt, t_pan, t_tilt, pan, tilt);
            m_pan = t_pan; m_tilt = t_tilt;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (pan !== 8'd128 || tilt !== 8'd128) begin
            errors++;
            $display("FAIL reset_pos: got %0d/%0d expected 128/128", pan, tilt);
        end
        checks++;
        if (update_valid !== 1'b0 || tracking !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b tracking=%b expected 0/0", update_valid, tracking);
        end
        reset = 1'b0;
        tick();
        m_pan = 128; m_tilt = 128; t_pan = 128; t_tilt = 128;
    endtask

    task automatic test_latency();
        logic [2:0] seen;
        update_ack = 1'b1;
        set_target(394, 419);
        strobe(394, 419);
        tick(); seen[0] = update_valid;
        tick(); seen[1] = update_valid;
        tick(); seen[2] = update_valid;
        checks++;
        if (seen !== 3'b100) begin
            errors++;
            $display("FAIL latency: valid after edges N+1..N+3 = %b expected 100", seen);
        end
        checks++;
        if (tracking !== 1'b1) begin
            errors++;
            $display("FAIL tracking_set: got %b expected 1", tracking);
        end
        drain(200);
    endtask

    task automatic test_hold_no_ack();
        do_reset();
        update_ack = 1'b0;
        set_target(754, 767);
        strobe(754, 767);
        wait_valid(10);
        m_pan  = step(m_pan, t_pan);
        m_tilt = step(m_tilt, t_tilt);
        checks++;
        if (pan !== 8'(m_pan) || tilt !== 8'(m_tilt)) begin
            errors++;
            $display("FAIL hold_first: got %0d/%0d expected %0d/%0d", pan, tilt, m_pan, m_tilt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (update_valid !== 1'b1 || pan !== 8'(m_pan) || tilt !== 8'(m_tilt)) begin
                errors++;
                $display("FAIL hold_stable: valid=%b pan=%0d tilt=%0d expected 1 %0d %0d",
                         update_valid, pan, tilt, m_pan, m_tilt);
            end
        end
        update_ack = 1'b1;
        tick();
        drain(200);
    endtask

    task automatic test_garbage();
        update_ack = 1'b1;
        set_target(2047, 0);
        strobe(2047, 0);
        drain(200);
    endtask

    task automatic test_random();
        update_ack = 1'b1;
        for (int n = 0; n < 8; n++) begin
            int x, y;
            x = int'($urandom_range(0, 2047));
            y = int'($urandom_range(0, 1023));
            set_target(x, y);
            strobe(x, y);
            drain(200);
        end
    endtask

    task automatic test_pending();
        int xa, ya, xb, yb, xc, yc;
        xa = int'($urandom_range(0, 2047)); ya = int'($urandom_range(0, 1023));
        xb = int'($urandom_range(0, 2047)); yb = int'($urandom_range(0, 1023));
        xc = int'($urandom_range(0, 2047)); yc = int'($urandom_range(0, 1023));
        update_ack = 1'b0;
        set_target(xa, ya);
        strobe(xa, ya);
        wait_valid(10);
        m_pan  = step(m_pan, t_pan);
        m_tilt = step(m_tilt, t_tilt);
        checks++;
        if (pan !== 8'(m_pan) || tilt !== 8'(m_tilt)) begin
            errors++;
            $display("FAIL pending_first: got %0d/%0d expected %0d/%0d", pan, tilt, m_pan, m_tilt);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 4)       strobe(xb, yb);
            else if (i == 10) strobe(xc, yc);
            else              tick();
            checks++;
            if (update_valid !== 1'b1 || pan !== 8'(m_pan) || tilt !== 8'(m_tilt)) begin
                errors++;
                $display("FAIL pending_hold: valid=%b pan=%0d tilt=%0d expected 1 %0d %0d",
                         update_valid, pan, tilt, m_pan, m_tilt);
            end
        end
        set_target(xc, yc);
        update_ack = 1'b1;
        tick();
        drain(200);
    endtask

    task automatic test_lost();
        int scyc;
        int bad_valid = 0;
        int bad_trk   = 0;
        do_reset();
        update_ack = 1'b1;
        set_target(600, 200);
        strobe(600, 200);
        scyc = cyc;
        drain(150);
        while (cyc < scyc + LOST - 1) tick();
        checks++;
        if (tracking !== 1'b1) begin
            errors++;
            $display("FAIL lost_early: tracking=%b one cycle before timeout expected 1", tracking);
        end
        tick();
        checks++;
        if (tracking !== 1'b0) begin
            errors++;
            $display("FAIL lost_drop: tracking=%b at timeout expected 0", tracking);
        end
        t_pan = 128; t_tilt = 128;
        drain(200);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (update_valid !== 1'b0) bad_valid++;
            if (tracking !== 1'b0) bad_trk++;
        end
        checks++;
        if (bad_valid != 0 || bad_trk != 0) begin
            errors++;
            $display("FAIL lost_repeat: %0d valid cycles and %0d tracking cycles after loss, expected 0/0",
                     bad_valid, bad_trk);
        end
    endtask

    task automatic test_async_reset();
        int x, y;
        int bad = 0;
        x = int'($urandom_range(0, 2047));
        y = int'($urandom_range(0, 1023));
        update_ack = 1'b0;
        set_target(x, y);
        strobe(x, y);
        wait_valid(10);
        strobe(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (update_valid !== 1'b0 || tracking !== 1'b0 || pan !== 8'd128 || tilt !== 8'd128) begin
            errors++;
            $display("FAIL async_reset: valid=%b tracking=%b pan=%0d tilt=%0d expected 0 0 128 128",
                     update_valid, tracking, pan, tilt);
        end
        tick();
        reset = 1'b0;
        m_pan = 128; m_tilt = 128; t_pan = 128; t_tilt = 128;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (update_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pending_discard: %0d valid cycles after reset expected 0", bad);
        end
        update_ack = 1'b1;
        set_target(x, y);
        strobe(x, y);
        drain(200);
    endtask

    initial begin
        reset      = 1'b1;
        x_com      = '0;
        y_com      = '0;
        data_ready = 1'b0;
        update_ack = 1'b0;
        test_reset();
        test_latency();
        test_hold_no_ack();
        test_garbage();
        test_random();
        test_pending();
        test_lost();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
